// File: rtl/pipeline_controller.sv
// Central sequencer for the 5-stage cpu: stage enables, NOP-flush strobes,
// start/halt/drain FSM, load-use stall insertion and saturating perf counters.
module pipeline_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rt_ID,
  input  logic             halt_ID,
  input  logic             mem_read_EX,
  input  logic [4:0]       regfile_waddr_EX,
  input  logic             branch_MEM,
  input  logic             zero_flag_MEM,
  input  logic             jump_MEM,
  output logic [4:0]       pipeline_en,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b11100;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_cnt_nxt;
  logic       take, load_use;
  logic       inc_cycle, inc_stall, inc_flush, clr_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign take     = jump_MEM | (branch_MEM & zero_flag_MEM);
  assign load_use = mem_read_EX && (regfile_waddr_EX != 5'd0) &&
                    ((regfile_waddr_EX == rs_ID) ||
                     (uses_rt_ID && (regfile_waddr_EX == rt_ID)));
  assign running  = (state == RUN) || (state == DRAIN);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pipeline_en   = 5'b00000;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    inc_cycle     = 1'b0;
    inc_stall     = 1'b0;
    inc_flush     = 1'b0;
    clr_cnt       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          clr_cnt   = 1'b1;
        end
      end
      RUN: begin
        if (enable) begin
          inc_cycle = 1'b1;
          if (take) begin
            // Everything younger than MEM is wrong-path, so halt/load-use are moot.
            pipeline_en  = EN_ALL;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            inc_flush    = 1'b1;
          end else if (load_use) begin
            pipeline_en = EN_STALL;
            flush_ID_EX = 1'b1;
            inc_stall   = 1'b1;
          end else if (halt_ID) begin
            pipeline_en   = EN_STALL;
            flush_ID_EX   = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = 2'd3;
          end else begin
            pipeline_en = EN_ALL;
          end
        end
      end
      DRAIN: begin
        if (enable) begin
          inc_cycle = 1'b1;
          if (take) begin
            // The halt sitting in IF/ID is wrong-path too; flush it with the rest.
            pipeline_en   = EN_ALL;
            flush_IF_ID   = 1'b1;
            flush_ID_EX   = 1'b1;
            flush_EX_MEM  = 1'b1;
            inc_flush     = 1'b1;
            state_nxt     = RUN;
            drain_cnt_nxt = 2'd0;
          end else begin
            pipeline_en   = EN_STALL;
            flush_ID_EX   = 1'b1;
            drain_cnt_nxt = drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      drain_cnt   <= 2'd0;
      cycle_count <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (clr_cnt) begin
        cycle_count <= '0;
        stall_count <= '0;
        flush_count <= '0;
      end else begin
        if (inc_cycle) cycle_count <= sat_inc(cycle_count);
        if (inc_stall) stall_count <= sat_inc(stall_count);
        if (inc_flush) flush_count <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller; narrow counters so saturation is reachable.
module tb_pipeline_controller;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          enable;
  logic [4:0]    rs_ID, rt_ID, regfile_waddr_EX;
  logic          uses_rt_ID, halt_ID, mem_read_EX;
  logic          branch_MEM, zero_flag_MEM, jump_MEM;
  logic [4:0]    pipeline_en;
  logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, running;
  logic [CW-1:0] cycle_count, stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  pipeline_controller #(.CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .halt_ID(halt_ID),
    .mem_read_EX(mem_read_EX), .regfile_waddr_EX(regfile_waddr_EX),
    .branch_MEM(branch_MEM), .zero_flag_MEM(zero_flag_MEM), .jump_MEM(jump_MEM),
    .pipeline_en(pipeline_en), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .running(running),
    .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] en, input logic fi,
                         input logic fd, input logic fe, input logic run);
    chk({tag, ".en"},  32'(pipeline_en), 32'(en));
    chk({tag, ".fif"}, 32'(flush_IF_ID), 32'(fi));
    chk({tag, ".fid"}, 32'(flush_ID_EX), 32'(fd));
    chk({tag, ".fem"}, 32'(flush_EX_MEM), 32'(fe));
    chk({tag, ".run"}, 32'(running), 32'(run));
  endtask

  task automatic chk_cnt(input string tag, input int cc, input int sc, input int fc);
    chk({tag, ".cyc"},   32'(cycle_count), 32'(cc));
    chk({tag, ".stall"}, 32'(stall_count), 32'(sc));
    chk({tag, ".flush"}, 32'(flush_count), 32'(fc));
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b0; rs_ID = '0; rt_ID = '0; uses_rt_ID = 1'b0;
    halt_ID = 1'b0; mem_read_EX = 1'b0; regfile_waddr_EX = '0;
    branch_MEM = 1'b0; zero_flag_MEM = 1'b0; jump_MEM = 1'b0;

    // Reset state
    #12;
    chk_ctl("rst", 5'b00000, 0, 0, 0, 0);
    chk_cnt("rst", 0, 0, 0);
    arst_n = 1'b1;
    tick(1);

    // Start and 10 clean RUN cycles
    enable = 1'b1; settle();
    chk_ctl("idle_en", 5'b00000, 0, 0, 0, 0);
    tick(1);
    chk_ctl("run0", 5'b11111, 0, 0, 0, 1);
    chk_cnt("run0", 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("run.en", 32'(pipeline_en), 32'h1f);
    end
    chk_cnt("run10", 10, 0, 0);

    // Load-use on rs
    mem_read_EX = 1'b1; regfile_waddr_EX = 5'd8; rs_ID = 5'd8; settle();
    chk_ctl("lu_rs", 5'b11100, 0, 1, 0, 1);
    tick(1);
    chk_cnt("lu_rs", 11, 1, 0);
    regfile_waddr_EX = 5'd0; rs_ID = 5'd0; settle();
    chk_ctl("lu_r0", 5'b11111, 0, 0, 0, 1);
    tick(1);
    chk_cnt("lu_r0", 12, 1, 0);

    // Load-use on rt, gated by uses_rt_ID
    regfile_waddr_EX = 5'd8; rs_ID = 5'd3; rt_ID = 5'd8; uses_rt_ID = 1'b0; settle();
    chk_ctl("lu_rt0", 5'b11111, 0, 0, 0, 1);
    uses_rt_ID = 1'b1; settle();
    chk_ctl("lu_rt1", 5'b11100, 0, 1, 0, 1);
    tick(1);
    chk_cnt("lu_rt1", 13, 2, 0);

    // Taken branch outranks the load-use hazard
    branch_MEM = 1'b1; zero_flag_MEM = 1'b1; settle();
    chk_ctl("br_tk", 5'b11111, 1, 1, 1, 1);
    tick(1);
    chk_cnt("br_tk", 14, 2, 1);
    zero_flag_MEM = 1'b0; settle();
    chk_ctl("br_nt_lu", 5'b11100, 0, 1, 0, 1);
    mem_read_EX = 1'b0; uses_rt_ID = 1'b0; settle();
    chk_ctl("br_nt", 5'b11111, 0, 0, 0, 1);
    tick(1);
    chk_cnt("br_nt", 15, 2, 1);
    branch_MEM = 1'b0;

    // Freeze for 4 cycles
    enable = 1'b0; settle();
    chk_ctl("frz", 5'b00000, 0, 0, 0, 1);
    tick(4);
    chk_ctl("frz4", 5'b00000, 0, 0, 0, 1);
    chk_cnt("frz4", 15, 2, 1);
    enable = 1'b1; settle();
    chk("unfrz.en", 32'(pipeline_en), 32'h1f);
    tick(1);
    chk_cnt("unfrz", 16, 2, 1);

    // Halt, 3 drain cycles, DONE
    halt_ID = 1'b1; settle();
    chk_ctl("halt", 5'b11100, 0, 1, 0, 1);
    tick(1);
    halt_ID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctl("drain", 5'b11100, 0, 1, 0, 1);
      tick(1);
    end
    chk_ctl("done", 5'b00000, 0, 0, 0, 0);
    chk_cnt("done", 20, 2, 1);
    tick(1);
    chk_ctl("done_hold", 5'b00000, 0, 0, 0, 0);
    enable = 1'b0;
    tick(1);
    chk_ctl("idle", 5'b00000, 0, 0, 0, 0);
    enable = 1'b1;
    tick(1);
    chk_ctl("rerun", 5'b11111, 0, 0, 0, 1);
    chk_cnt("rerun", 0, 0, 0);

    // Redirect during DRAIN returns to RUN
    halt_ID = 1'b1;
    tick(1);
    halt_ID = 1'b0; jump_MEM = 1'b1; settle();
    chk("dr_jmp.en", 32'(pipeline_en), 32'h1f);
    chk("dr_jmp.fem", 32'(flush_EX_MEM), 32'h1);
    tick(1);
    jump_MEM = 1'b0; settle();
    chk_ctl("dr_back", 5'b11111, 0, 0, 0, 1);
    chk_cnt("dr_back", 2, 0, 1);

    // Async reset mid-DRAIN
    halt_ID = 1'b1;
    tick(1);
    halt_ID = 1'b0; settle();
    chk_ctl("drain2", 5'b11100, 0, 1, 0, 1);
    arst_n = 1'b0; #1;
    chk_ctl("arst", 5'b00000, 0, 0, 0, 0);
    chk_cnt("arst", 0, 0, 0);
    tick(1);
    arst_n = 1'b1;

    // Counter saturation at 2^CW-1
    tick(1);
    tick(1);
    for (int i = 0; i < 40; i++) tick(1);
    chk_cnt("sat", 31, 0, 0);
    chk("sat.en", 32'(pipeline_en), 32'h1f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central sequencer for the 5-stage pipelined cpu (IF, ID, EX, MEM, WB). Generates the per-stage enables (pipeline_en) and NOP-flush strobes for the pipeline registers, and runs a start/halt/drain state machine. Also detects load-use hazards, converting them into one-cycle stalls, and redirects on taken branches and jumps. It keeps saturating performance counters readable by the testbench.

Parameters:
CNT_W, 32, width of cycle_count, stall_count and flush_count.

Ports:
clk  input  1  main clock
arst_n  input  1  asynchronous active-low reset
enable  input  1  run request (level); low = freeze whole pipeline
rs_ID  input  5  instruction_ID[25:21]
rt_ID  input  5  instruction_ID[20:16]
uses_rt_ID  input  1  ID instruction reads rt (R-type, beq, sw)
halt_ID  input  1  ID instruction is the halt encoding
mem_read_EX  input  1  EX instruction is a load
regfile_waddr_EX  input  5  EX destination register
branch_MEM  input  1  MEM instruction is a branch
zero_flag_MEM  input  1  registered ALU zero flag of MEM instruction
jump_MEM  input  1  MEM instruction is a jump
pipeline_en  output  5  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
flush_IF_ID  output  1  IF/ID loads NOP at the next edge
flush_ID_EX  output  1  ID/EX loads NOP (all control bits 0) at the next edge
flush_EX_MEM  output  1  EX/MEM loads NOP at the next edge
running  output  1  high in RUN or DRAIN
cycle_count  output  CNT_W  active cycles since start
stall_count  output  CNT_W  load-use stall cycles
flush_count  output  CNT_W  taken branch/jump redirects

Behaviour:
- Reset (arst_n=0, async): state IDLE, drain counter 0, all counters 0. Outputs: pipeline_en=0, all flush=0, running=0.
- States: IDLE, RUN, DRAIN, DONE. Registered state; enables and flushes are combinational from state and inputs, effective at the next clk edge.
- IDLE: pipeline_en=0. On enable=1, go to RUN and clear all three counters in the same edge.
- RUN with enable=0: pipeline_en=0, flush=0, counters hold. The cpu freezes in place and resumes on enable=1.
- RUN, enable=1, cases in priority order:
  1. Taken redirect (take = jump_MEM | (branch_MEM & zero_flag_MEM)): pipeline_en=5'b11111. flush_IF_ID, flush_ID_EX and flush_EX_MEM are all 1. flush_count is incremented. halt_ID and load-use checks are ignored because those instructions are wrong-path.
  2. Load-use hazard (mem_read_EX & regfile_waddr_EX!=0 & (regfile_waddr_EX==rs_ID | (uses_rt_ID & regfile_waddr_EX==rt_ID))): pipeline_en=5'b11100, flush_ID_EX=1, stall_count is incremented. Exactly one bubble per load; the next cycle sees a NOP in EX. halt_ID is not evaluated while stalled.
  3. halt_ID=1: pipeline_en=5'b11100, flush_ID_EX=1. Go to DRAIN with the drain counter loaded to 3.
  4. Otherwise: pipeline_en=5'b11111, no flush.
- DRAIN:
  - pipeline_en=5'b11100, flush_ID_EX=1 every cycle, so no new instructions enter EX.
  - The drain counter decrements each cycle; at 0, go to DONE. Older instructions complete through WB.
  - A taken redirect in MEM during DRAIN flushes EX/MEM and returns to RUN, with pipeline_en=5'b11111 and flush_count incremented.
  - enable=0 freezes DRAIN: all enables 0, counter holds.
- DONE: pipeline_en=0, running=0. On enable=0, go to IDLE, so a new run needs an enable low-to-high sequence.
- cycle_count increments in every RUN or DRAIN cycle with enable=1.
- All counters saturate at 2^CNT_W-1 and never wrap.
- An async reset mid-run returns immediately to the reset values, regardless of state.

Test Plan:
- Reset then enable=1 with no hazards, 10 cycles: pipeline_en=5'b11111 throughout, cycle_count=10, stall_count=0, running=1.
- lw to $t0 in EX (mem_read_EX=1, waddr_EX=8), rs_ID=8: for one cycle pipeline_en=5'b11100 and flush_ID_EX=1, stall_count=1. With waddr_EX=0 there is no stall.
- Load-use condition with rt_ID=8 but uses_rt_ID=0: no stall. The same inputs with uses_rt_ID=1 produce a stall.
- branch_MEM=1, zero_flag_MEM=1 asserted together with a load-use hazard: all three flushes are 1, pipeline_en=5'b11111, flush_count=1, stall_count unchanged. With zero_flag_MEM=0: no flush.
- halt_ID=1 in RUN: 1 cycle with flush_ID_EX, then 3 DRAIN cycles, then DONE with pipeline_en=0 and running=0. Dropping enable returns to IDLE; re-raising enable clears the counters.
- Drop enable mid-RUN for 4 cycles, and separately pulse arst_n low mid-DRAIN. Frozen: pipeline_en=0, counters hold. Reset: outputs and counters return to 0 asynchronously.
